// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_ranger
// Purpose  : HC-SR04-style range controller. Issues a trigger pulse, times
//            the echo pulse in microseconds, reports the width with a valid
//            strobe, a timeout strobe and a near-threshold flag. Supports
//            single-shot and continuous periodic ranging.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   start       in   single-shot request, honoured in IDLE only
//   continuous  in   1 = re-trigger automatically every PERIOD_US
//   echo        in   sensor echo pin (asynchronous)
//   threshold   in   [WIDTH] near compare limit in us, sampled at capture
//   trigger     out  sensor trigger pin
//   busy        out  high in every state except IDLE
//   echo_us     out  [WIDTH] last valid echo width in us
//   valid       out  one-clock pulse, new echo_us captured
//   timeout     out  one-clock pulse, cycle ended without a valid echo
//   near        out  echo_us < threshold at the last valid capture
// ============================================================================
module ultrasonic_ranger #(
    parameter int CLKS_PER_US = 50,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int PERIOD_US   = 60000,
    parameter int WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             echo,
    input  logic [WIDTH-1:0] threshold,
    output logic             trigger,
    output logic             busy,
    output logic [WIDTH-1:0] echo_us,
    output logic             valid,
    output logic             timeout,
    output logic             near
);

    localparam int PSW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int PCW = $clog2(PERIOD_US + 1);
    localparam int TOW = $clog2(TIMEOUT_US + 1);

    localparam logic [PSW-1:0]   PRESC_LAST   = PSW'(CLKS_PER_US - 1);
    localparam logic [PCW-1:0]   PERIOD_MAX   = PCW'(PERIOD_US);
    localparam logic [PCW-1:0]   TRIG_LAST    = PCW'(TRIG_US - 1);
    localparam logic [TOW-1:0]   TIMEOUT_LAST = TOW'(TIMEOUT_US - 1);
    localparam logic [WIDTH-1:0] WIDTH_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       echo_sync;
    logic             echo_s;
    logic [PSW-1:0]   presc;
    logic             tick;
    logic [PCW-1:0]   period_cnt;
    logic [TOW-1:0]   wait_cnt;     // timeout budget in WAIT_RISE and MEASURE
    logic [WIDTH-1:0] width_cnt;
    logic             capture;
    logic             expire;

    assign echo_s  = echo_sync[1];
    assign busy    = (state != IDLE);
    assign trigger = (state == TRIG);

    // The prescaler is held at zero in IDLE, so the first tick of a cycle
    // lands exactly CLKS_PER_US clocks after the trigger rises and every
    // us-count below is aligned to the trigger edge.
    assign tick = (state != IDLE) && (presc == PRESC_LAST);

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (start || continuous) begin
                    state_next = TRIG;
                end
            end
            TRIG: begin
                // period_cnt counts us since trigger rise; leave on the
                // tick that completes TRIG_US.
                if (tick && (period_cnt == TRIG_LAST)) begin
                    state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // Checked every clock, so an echo already high on entry
                // is taken as the rise.
                if (echo_s) begin
                    state_next = MEASURE;
                end else if (tick && (wait_cnt == TIMEOUT_LAST)) begin
                    expire     = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    capture    = 1'b1;
                    state_next = HOLDOFF;
                end else if (tick && (wait_cnt == TIMEOUT_LAST)) begin
                    expire     = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (period_cnt >= PERIOD_MAX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, synchronizer, counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            echo_sync  <= '0;
            presc      <= '0;
            period_cnt <= '0;
            wait_cnt   <= '0;
            width_cnt  <= '0;
            echo_us    <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            near       <= 1'b0;
        end else begin
            state     <= state_next;
            echo_sync <= {echo_sync[0], echo};
            valid     <= capture;
            timeout   <= expire;

            // TRIG is only reachable from IDLE, so holding these at zero in
            // IDLE is the same as clearing them on TRIG entry.
            if (state == IDLE) begin
                presc      <= '0;
                period_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && (period_cnt != PERIOD_MAX)) begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end

            // Restarted on every state change so WAIT_RISE and MEASURE each
            // get a fresh TIMEOUT_US budget.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (tick && ((state == WAIT_RISE) || (state == MEASURE))) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if ((state_next == MEASURE) && (state != MEASURE)) begin
                width_cnt <= '0;
            end else if ((state == MEASURE) && tick && (width_cnt != WIDTH_MAX)) begin
                width_cnt <= width_cnt + 1'b1;
            end

            if (capture) begin
                echo_us <= width_cnt;
                near    <= (width_cnt < threshold);
            end else if (expire) begin
                near <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_ranger
// Purpose  : Self-checking bench for ultrasonic_ranger with a timeline
//            reference model, directed scenarios and randomized ranging.
// Revision : 1.0  initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int CPU         = 4;
    localparam int TRIG_US     = 10;
    localparam int TIMEOUT_US  = 100;
    localparam int PERIOD_US   = 300;
    localparam int W           = 8;
    localparam int TRIG_CLKS   = TRIG_US * CPU;              // 40
    localparam int TO_CLKS     = TIMEOUT_US * CPU;           // 400
    localparam int IDLE_EDGE   = PERIOD_US * CPU + 1;        // 1201: IDLE entered
    localparam int NO_ECHO     = 5000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic         echo = 1'b0;
    logic [W-1:0] threshold = '0;
    logic         trigger, busy, valid, timeout, near;
    logic [W-1:0] echo_us;

    ultrasonic_ranger #(
        .CLKS_PER_US (CPU),
        .TRIG_US     (TRIG_US),
        .TIMEOUT_US  (TIMEOUT_US),
        .PERIOD_US   (PERIOD_US),
        .WIDTH       (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .echo       (echo),
        .threshold  (threshold),
        .trigger    (trigger),
        .busy       (busy),
        .echo_us    (echo_us),
        .valid      (valid),
        .timeout    (timeout),
        .near       (near)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;     // number of the last rising edge

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Echo is planned relative to the trigger rise edge:
    // high for the samples taken at relative edges [plan_a, plan_b).
    // At each trigger rise the whole cycle outcome is computed from that
    // plan with timeline arithmetic.
    // ------------------------------------------------------------------
    int plan_a = NO_ECHO, plan_b = NO_ECHO;
    int m_a = NO_ECHO, m_b = NO_ECHO;
    bit m_started = 0;
    int m_t0 = 0, m_busy_until = 0, m_ev = -1, m_us = 0;
    bit m_is_valid = 0;
    bit exp_trigger = 0, exp_busy = 0, exp_valid = 0, exp_timeout = 0, exp_near = 0;
    int exp_us = 0;

    // Echo seen by the controller lags the pin by two clocks; decisions
    // take one more clock. Ticks sit on multiples of CPU from trigger rise.
    function automatic void predict(input int a, input int b,
                                    output int ev, output bit is_valid, output int us);
        int first_seen, last_seen, r, x, f;
        first_seen = (a + 1 > TRIG_CLKS) ? a + 1 : TRIG_CLKS;
        last_seen  = (b < TRIG_CLKS + TO_CLKS - 1) ? b : TRIG_CLKS + TO_CLKS - 1;
        is_valid = 0;
        us = 0;
        if (first_seen <= last_seen) begin
            r = first_seen + 1;                    // measurement starts
            x = (r / CPU + TIMEOUT_US) * CPU;      // 100th tick after start
            f = b + 2;                             // fall observed and captured
            if (f <= x) begin
                ev = f;
                is_valid = 1;
                us = (b + 1) / CPU - r / CPU;
                if (us > 255) us = 255;
            end else begin
                ev = x;
            end
        end else begin
            ev = TRIG_CLKS + TO_CLKS;              // no rise in the wait window
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int e, ev_rel;
        if (rst) begin
            m_started   = 0;
            m_busy_until = 0;
            m_ev        = -1;
            exp_trigger = 0;
            exp_busy    = 0;
            exp_valid   = 0;
            exp_timeout = 0;
            exp_near    = 0;
            exp_us      = 0;
        end else begin
            e = cyc + 1;
            exp_valid   = 0;
            exp_timeout = 0;
            if ((!m_started || (e - 1 >= m_busy_until)) && (start || continuous)) begin
                m_started    = 1;
                m_t0         = e;
                m_busy_until = e + IDLE_EDGE;
                m_a          = plan_a;
                m_b          = plan_b;
                predict(m_a, m_b, ev_rel, m_is_valid, m_us);
                m_ev = m_t0 + ev_rel;
            end
            if (m_started && (e == m_ev)) begin
                if (m_is_valid) begin
                    exp_valid = 1;
                    exp_us    = m_us;
                    exp_near  = (m_us < int'(threshold));
                end else begin
                    exp_timeout = 1;
                    exp_near    = 0;
                end
            end
            exp_trigger = m_started && ((e - m_t0) < TRIG_CLKS);
            exp_busy    = m_started && (e < m_busy_until);
        end
    end

    always @(negedge clk) begin : echo_drv
        int rel;
        rel = cyc + 1 - m_t0;
        echo = !rst && m_started && (rel >= m_a) && (rel < m_b);
    end

    always @(negedge clk) begin : compare
        if (!rst) begin
            checks++;
            if (trigger !== exp_trigger || busy !== exp_busy || valid !== exp_valid ||
                timeout !== exp_timeout || near !== exp_near || int'(echo_us) != exp_us) begin
                errors++;
                $display("FAIL cycle_compare @%0d: dut trig=%b busy=%b valid=%b to=%b near=%b us=%0d model trig=%b busy=%b valid=%b to=%b near=%b us=%0d",
                         cyc, trigger, busy, valid, timeout, near, echo_us,
                         exp_trigger, exp_busy, exp_valid, exp_timeout, exp_near, exp_us);
            end
        end
    end

    // ------------------------------------------------------------------
    // Event monitor for the literal timing expectations
    // ------------------------------------------------------------------
    int rises[$];
    int last_fall = 0, busy_fall = 0, to_cyc = 0, valid_cnt = 0, to_cnt = 0;
    logic trig_d = 0, busy_d = 0;

    always @(posedge clk) begin
        #1;
        if (trigger && !trig_d) rises.push_back(cyc);
        if (!trigger && trig_d) last_fall = cyc;
        if (!busy && busy_d)    busy_fall = cyc;
        if (valid) valid_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        trig_d = trigger;
        busy_d = busy;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_rises(input string name, input int count, input int budget);
        int n = 0;
        while (rises.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, rises.size(), count);
    endtask

    task automatic wait_until(input int target, input int budget);
        int n = 0;
        while (cyc < target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_single(input int a, input int b, input int thr);
        plan_a = a;
        plan_b = b;
        threshold = W'(thr);
        @(negedge clk);
        pulse_start();
        wait_idle("single_shot_done", 1500);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int v0, t0c, n0, r0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {trigger, busy, valid, timeout, near, echo_us}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_without_start", busy, 0);

        // Echo 20 us after trigger fall, 228 clocks wide; threshold 60
        v0 = valid_cnt;
        run_single(TRIG_CLKS + 80, TRIG_CLKS + 80 + 228, 60);
        check("trigger_width", last_fall - rises[$], 40);
        check("valid_once", valid_cnt - v0, 1);
        check("echo_us_57", echo_us, 57);
        check("near_thr60", near, 1);
        // IDLE is entered one clock before the next possible trigger, which
        // keeps continuous trigger rises PERIOD*CPU+2 apart.
        check("busy_fall_delay", busy_fall - rises[$], IDLE_EDGE);

        // Same echo, threshold 50
        run_single(TRIG_CLKS + 80, TRIG_CLKS + 80 + 228, 50);
        check("echo_us_57_again", echo_us, 57);
        check("near_thr50", near, 0);

        // Echo held low
        v0 = valid_cnt;
        t0c = to_cnt;
        run_single(NO_ECHO, NO_ECHO, 200);
        check("timeout_after_fall", to_cyc - last_fall, 400);
        check("no_valid_on_timeout", valid_cnt - v0, 0);
        check("timeout_once", to_cnt - t0c, 1);
        check("echo_us_kept", echo_us, 57);
        check("near_cleared", near, 0);

        // Echo stuck high from just after trigger: width timeout
        v0 = valid_cnt;
        t0c = to_cnt;
        run_single(1, 601, 200);
        check("stuck_timeout_at", to_cyc - rises[$], 440);
        check("stuck_no_valid", valid_cnt - v0, 0);
        check("stuck_timeout_once", to_cnt - t0c, 1);

        // Continuous ranging with a 30 us echo; third cycle stuck high
        n0 = rises.size();
        v0 = valid_cnt;
        t0c = to_cnt;
        plan_a = 60;
        plan_b = 180;
        threshold = 8'd40;
        continuous = 1'b1;
        wait_rises("cont_rise2", n0 + 2, 3000);
        plan_a = 1;
        plan_b = 601;
        wait_rises("cont_rise3", n0 + 3, 1500);
        plan_a = 60;
        plan_b = 180;
        wait_rises("cont_rise4", n0 + 4, 1500);
        pulse_start();
        wait_until(rises[$] + 120, 200);
        continuous = 1'b0;
        wait_until(rises[$] + 1100, 1200);
        pulse_start();
        repeat (1500) @(negedge clk);
        check("cont_no_extra_trigger", rises.size(), n0 + 4);
        check("cont_spacing_1", rises[n0 + 1] - rises[n0], 1202);
        check("cont_spacing_2", rises[n0 + 2] - rises[n0 + 1], 1202);
        check("cont_spacing_3", rises[n0 + 3] - rises[n0 + 2], 1202);
        check("cont_valids", valid_cnt - v0, 3);
        check("cont_timeouts", to_cnt - t0c, 1);
        check("cont_echo_us_30", echo_us, 30);
        check("cont_near", near, 1);

        // Asynchronous reset in the middle of a measurement
        r0 = rises.size();
        continuous = 1'b1;
        wait_rises("rst_case_rise", r0 + 1, 1500);
        wait_until(rises[$] + 120, 200);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {trigger, busy, valid, timeout, near, echo_us}, 0);
        continuous = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_after_reset", busy, 0);
        check("no_trigger_after_reset", rises.size(), r0 + 1);

        // Randomized ranging against the model
        continuous = 1'b1;
        repeat (20000) begin
            @(negedge clk);
            start = ($urandom_range(0, 19) == 0);
            threshold = W'($urandom_range(0, 127));
            if ($urandom_range(0, 2999) == 0) continuous = ~continuous;
            if (m_started && (cyc == m_t0)) begin
                case ($urandom_range(0, 3))
                    0: begin
                        plan_a = NO_ECHO;
                        plan_b = NO_ECHO;
                    end
                    1: begin
                        plan_a = $urandom_range(1, 60);
                        plan_b = plan_a + $urandom_range(400, 700);
                    end
                    default: begin
                        plan_a = $urandom_range(1, 480);
                        plan_b = plan_a + $urandom_range(1, 440);
                    end
                endcase
            end
        end
        start = 1'b0;
        continuous = 1'b0;
        wait_idle("final_idle", 1500);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
